// File: rtl/dmem_bridge_if.sv
// ---------------------------------------------------------------------------
// dmem_bridge_if
// SRAM-like data bus between the memory-stage bridge (master) and the data
// memory / cache (slave). One request is accepted per addr_ok; every accepted
// request gets exactly one data_ok response in a later cycle.
//
// Signals
//   data_sram_req      master -> slave   request valid
//   data_sram_wr       master -> slave   1 = write, 0 = read
//   data_sram_size     master -> slave   0 byte, 1 half, 2 word
//   data_sram_addr     master -> slave   byte address
//   data_sram_wstrb    master -> slave   byte enables (ignored for reads)
//   data_sram_wdata    master -> slave   write data, lane-aligned
//   data_sram_addr_ok  slave -> master   request accepted this cycle
//   data_sram_data_ok  slave -> master   read data / write ack this cycle
//   data_sram_rdata    slave -> master   read data, valid with data_ok
// ---------------------------------------------------------------------------
interface dmem_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  data_sram_req;
    logic                  data_sram_wr;
    logic [1:0]            data_sram_size;
    logic [ADDR_W-1:0]     data_sram_addr;
    logic [DATA_W/8-1:0]   data_sram_wstrb;
    logic [DATA_W-1:0]     data_sram_wdata;
    logic                  data_sram_addr_ok;
    logic                  data_sram_data_ok;
    logic [DATA_W-1:0]     data_sram_rdata;

    modport master (
        output data_sram_req, data_sram_wr, data_sram_size, data_sram_addr,
               data_sram_wstrb, data_sram_wdata,
        input  data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
    );

    modport slave (
        input  data_sram_req, data_sram_wr, data_sram_size, data_sram_addr,
               data_sram_wstrb, data_sram_wdata,
        output data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
    );
endinterface

// File: rtl/dmem_bridge.sv
// ---------------------------------------------------------------------------
// dmem_bridge
// Memory-stage data-access bridge. Issues each M-stage load/store exactly once
// on the SRAM-like data bus, reports dmem_busy to the hazard unit, and holds
// load data while the pipeline is frozen for other reasons.
//
// Ports
//   clk        system clock, rising edge
//   resetn     asynchronous active-low reset
//   m_req      M-stage instruction is a (non-faulting) load/store
//   m_wr       1 = store, 0 = load
//   m_size     0 byte, 1 half, 2 word (3 treated as word)
//   m_addr     byte address
//   m_wdata    store data, lane-aligned
//   m_stall    final M-stage stall from the hazard unit
//   m_flush    final M-stage flush from the hazard unit
//   dmem_busy  M-stage access not yet complete (never depends on stall/flush)
//   m_rdata    load result toward the M/W path
//   bus        data bus, master side
// ---------------------------------------------------------------------------
module dmem_bridge #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               m_req,
    input  logic               m_wr,
    input  logic [1:0]         m_size,
    input  logic [ADDR_W-1:0]  m_addr,
    input  logic [DATA_W-1:0]  m_wdata,
    input  logic               m_stall,
    input  logic               m_flush,
    output logic               dmem_busy,
    output logic [DATA_W-1:0]  m_rdata,
    dmem_bridge_if.master      bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE,
        S_DRAIN
    } state_t;

    state_t               r_state;
    state_t               w_next;

    logic                 r_wr;
    logic [1:0]           r_size;
    logic [ADDR_W-1:0]    r_addr;
    logic [DATA_W-1:0]    r_wdata;
    logic [3:0]           r_wstrb;
    logic [DATA_W-1:0]    r_rdata;
    logic                 r_cancel;

    logic                 w_busy;
    logic                 w_req;
    logic                 w_wr;
    logic [1:0]           w_size;
    logic [ADDR_W-1:0]    w_addr;
    logic [DATA_W-1:0]    w_wdata;
    logic [3:0]           w_wstrb;
    logic [DATA_W-1:0]    w_rdata;
    logic                 w_issue;
    logic                 w_capture;

    // Byte enables from size and the low address bits; size 3 behaves as word.
    function automatic logic [3:0] f_wstrb(input logic [1:0] size, input logic [1:0] lo);
        logic [3:0] strb;
        case (size)
            2'd0:    strb = 4'b0001 << lo;
            2'd1:    strb = lo[1] ? 4'b1100 : 4'b0011;
            default: strb = 4'b1111;
        endcase
        return strb;
    endfunction

    always_comb begin
        w_next    = r_state;
        w_busy    = 1'b0;
        w_req     = 1'b0;
        w_wr      = r_wr;
        w_size    = r_size;
        w_addr    = r_addr;
        w_wdata   = r_wdata;
        w_wstrb   = r_wstrb;
        w_rdata   = r_rdata;
        w_issue   = 1'b0;
        w_capture = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                // Bus fields come straight from M so an access can issue in
                // the same cycle the instruction arrives.
                w_busy  = m_req;
                w_req   = m_req && !m_flush;
                w_wr    = m_wr;
                w_size  = m_size;
                w_addr  = m_addr;
                w_wdata = m_wdata;
                w_wstrb = f_wstrb(m_size, m_addr[1:0]);
                if (w_req) begin
                    w_issue = 1'b1;
                    w_next  = bus.data_sram_addr_ok ? S_WAIT : S_REQ;
                end
            end
            S_REQ: begin
                // A presented request is never withdrawn; a flush only marks
                // the eventual response for discard.
                w_busy = 1'b1;
                w_req  = 1'b1;
                if (bus.data_sram_addr_ok) begin
                    w_next = (r_cancel || m_flush) ? S_DRAIN : S_WAIT;
                end
            end
            S_WAIT: begin
                w_busy = !bus.data_sram_data_ok;
                if (bus.data_sram_data_ok) begin
                    w_rdata   = bus.data_sram_rdata;
                    w_capture = 1'b1;
                    if (m_flush)      w_next = S_IDLE;
                    else if (m_stall) w_next = S_DONE;
                    else              w_next = S_IDLE;
                end else if (m_flush) begin
                    w_next = S_DRAIN;
                end
            end
            S_DONE: begin
                // Access finished but the instruction is still held in M.
                if (!m_stall || m_flush) w_next = S_IDLE;
            end
            S_DRAIN: begin
                w_busy = 1'b1;
                if (bus.data_sram_data_ok) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= S_IDLE;
            r_wr     <= 1'b0;
            r_size   <= 2'd0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_wstrb  <= 4'd0;
            r_rdata  <= '0;
            r_cancel <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_issue) begin
                r_wr    <= w_wr;
                r_size  <= w_size;
                r_addr  <= w_addr;
                r_wdata <= w_wdata;
                r_wstrb <= w_wstrb;
            end
            if (w_capture) r_rdata <= bus.data_sram_rdata;
            if (w_next == S_IDLE)                   r_cancel <= 1'b0;
            else if (r_state == S_REQ && m_flush)   r_cancel <= 1'b1;
        end
    end

    // resetn gates the combinational outputs so nothing leaks from M while
    // the block is held in reset.
    assign dmem_busy           = resetn && w_busy;
    assign m_rdata             = w_rdata;
    assign bus.data_sram_req   = resetn && w_req;
    assign bus.data_sram_wr    = w_wr;
    assign bus.data_sram_size  = w_size;
    assign bus.data_sram_addr  = w_addr;
    assign bus.data_sram_wdata = w_wdata;
    assign bus.data_sram_wstrb = w_wstrb;

endmodule

// File: tb/tb_dmem_bridge.sv
// ---------------------------------------------------------------------------
// tb_dmem_bridge
// Self-checking bench for dmem_bridge. Expected bus requests and load results
// are pushed to queues when stimulus is driven and popped when the bridge
// presents them.
// ---------------------------------------------------------------------------
module tb_dmem_bridge;

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } req_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic        m_req, m_wr, m_stall, m_flush;
    logic [1:0]  m_size;
    logic [31:0] m_addr, m_wdata;
    logic        dmem_busy;
    logic [31:0] m_rdata;

    int checks = 0;
    int failures = 0;
    int n_accept = 0;
    int base;

    req_t        exp_q[$];
    logic [31:0] rd_q[$];
    req_t        e, e0, got;
    logic [31:0] exp_rd;

    logic [1:0]  sw_size [7] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd3};
    logic [1:0]  sw_lo   [7] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd2, 2'd0};
    logic [3:0]  sw_strb [7] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};

    dmem_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    dmem_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .m_req     (m_req),
        .m_wr      (m_wr),
        .m_size    (m_size),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_stall   (m_stall),
        .m_flush   (m_flush),
        .dmem_busy (dmem_busy),
        .m_rdata   (m_rdata),
        .bus       (bus.master)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (resetn && bus.data_sram_req && bus.data_sram_addr_ok) n_accept <= n_accept + 1;

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    function automatic req_t bus_sample();
        req_t r;
        r.wr    = bus.data_sram_wr;
        r.size  = bus.data_sram_size;
        r.addr  = bus.data_sram_addr;
        r.wstrb = bus.data_sram_wstrb;
        r.wdata = bus.data_sram_wdata;
        return r;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic drive_quiet();
        m_req = 0; m_wr = 0; m_size = 0; m_addr = 0; m_wdata = 0;
        m_stall = 0; m_flush = 0;
        bus.data_sram_addr_ok = 0; bus.data_sram_data_ok = 0; bus.data_sram_rdata = 0;
    endtask

    task automatic set_instr(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [3:0] strb);
        req_t r;
        m_req = 1; m_wr = wr; m_size = size; m_addr = addr; m_wdata = wdata;
        r.wr = wr; r.size = size; r.addr = addr; r.wstrb = strb; r.wdata = wdata;
        exp_q.push_back(r);
    endtask

    task automatic test_reset();
        drive_quiet();
        resetn = 0;
        m_req = 1; m_addr = 32'h10; m_size = 2;
        #3;
        checks++; if (bus.data_sram_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", bus.data_sram_req); end
        checks++; if (dmem_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", dmem_busy); end
        checks++; if (m_rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", m_rdata); end
        cyc(); cyc();
        drive_quiet();
        resetn = 1;
        cyc();
    endtask

    task automatic test_load_word();
        base = n_accept;
        set_instr(0, 2'd2, 32'h0000_0104, 32'h0, 4'b1111);
        bus.data_sram_addr_ok = 1;
        settle();
        checks++; if (bus.data_sram_req !== 1'b1 || dmem_busy !== 1'b1) begin failures++; $display("FAIL load_issue req=%b busy=%b exp=1,1", bus.data_sram_req, dmem_busy); end
        got = bus_sample(); e = exp_q.pop_front();
        checks++; if (got !== e) begin failures++; $display("FAIL load_fields got=%h exp=%h", got, e); end
        cyc();
        bus.data_sram_addr_ok = 0;
        for (int i = 0; i < 2; i++) begin
            settle();
            checks++; if (bus.data_sram_req !== 1'b0 || dmem_busy !== 1'b1) begin failures++; $display("FAIL load_wait%0d req=%b busy=%b exp=0,1", i, bus.data_sram_req, dmem_busy); end
            cyc();
        end
        bus.data_sram_data_ok = 1; bus.data_sram_rdata = 32'hDEAD_BEEF;
        rd_q.push_back(32'hDEAD_BEEF);
        settle();
        exp_rd = rd_q.pop_front();
        checks++; if (dmem_busy !== 1'b0) begin failures++; $display("FAIL load_dataok_busy got=%b exp=0", dmem_busy); end
        checks++; if (m_rdata !== exp_rd) begin failures++; $display("FAIL load_rdata got=%h exp=%h", m_rdata, exp_rd); end
        cyc();
        drive_quiet();
        settle();
        checks++; if (m_rdata !== exp_rd || dmem_busy !== 1'b0) begin failures++; $display("FAIL load_after rdata=%h busy=%b exp=%h,0", m_rdata, dmem_busy, exp_rd); end
        cyc();
        checks++; if (n_accept - base !== 1) begin failures++; $display("FAIL load_accepts got=%0d exp=1", n_accept - base); end
    endtask

    task automatic test_byte_store();
        base = n_accept;
        set_instr(1, 2'd0, 32'h0000_1003, 32'hAB00_0000, 4'b1000);
        e0 = exp_q[exp_q.size()-1];
        for (int i = 0; i < 4; i++) begin
            bus.data_sram_addr_ok = (i == 3);
            settle();
            got = bus_sample();
            checks++; if (bus.data_sram_req !== 1'b1 || got !== e0) begin failures++; $display("FAIL store_stable%0d req=%b got=%h exp=%h", i, bus.data_sram_req, got, e0); end
            if (i == 3) begin
                e = exp_q.pop_front();
                checks++; if (got !== e) begin failures++; $display("FAIL store_accept got=%h exp=%h", got, e); end
            end
            cyc();
        end
        bus.data_sram_addr_ok = 0; bus.data_sram_data_ok = 1;
        settle();
        checks++; if (dmem_busy !== 1'b0) begin failures++; $display("FAIL store_done_busy got=%b exp=0", dmem_busy); end
        cyc();
        drive_quiet();
        cyc();
        checks++; if (n_accept - base !== 1) begin failures++; $display("FAIL store_accepts got=%0d exp=1", n_accept - base); end
    endtask

    task automatic test_stall_hold();
        base = n_accept;
        set_instr(0, 2'd2, 32'h0000_0200, 32'h0, 4'b1111);
        bus.data_sram_addr_ok = 1;
        settle();
        got = bus_sample(); e = exp_q.pop_front();
        checks++; if (got !== e) begin failures++; $display("FAIL stall_fields got=%h exp=%h", got, e); end
        cyc();
        bus.data_sram_addr_ok = 0; bus.data_sram_data_ok = 1; bus.data_sram_rdata = 32'h1234_5678;
        m_stall = 1;
        rd_q.push_back(32'h1234_5678);
        settle();
        exp_rd = rd_q.pop_front();
        checks++; if (m_rdata !== exp_rd || dmem_busy !== 1'b0) begin failures++; $display("FAIL stall_dataok rdata=%h busy=%b exp=%h,0", m_rdata, dmem_busy, exp_rd); end
        cyc();
        bus.data_sram_data_ok = 0; bus.data_sram_rdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 4; i++) begin
            settle();
            checks++; if (m_rdata !== exp_rd || dmem_busy !== 1'b0 || bus.data_sram_req !== 1'b0) begin failures++; $display("FAIL stall_hold%0d rdata=%h busy=%b req=%b exp=%h,0,0", i, m_rdata, dmem_busy, bus.data_sram_req, exp_rd); end
            cyc();
        end
        m_stall = 0;
        settle();
        checks++; if (dmem_busy !== 1'b0 || bus.data_sram_req !== 1'b0) begin failures++; $display("FAIL stall_release busy=%b req=%b exp=0,0", dmem_busy, bus.data_sram_req); end
        cyc();
        drive_quiet();
        settle();
        checks++; if (bus.data_sram_req !== 1'b0 || n_accept - base !== 1) begin failures++; $display("FAIL stall_single req=%b accepts=%0d exp=0,1", bus.data_sram_req, n_accept - base); end
        cyc();
    endtask

    task automatic test_flush_drain();
        m_req = 1; m_flush = 1; m_size = 2; m_addr = 32'h0000_0F00;
        settle();
        checks++; if (bus.data_sram_req !== 1'b0 || dmem_busy !== 1'b1) begin failures++; $display("FAIL idle_flush req=%b busy=%b exp=0,1", bus.data_sram_req, dmem_busy); end
        cyc();
        drive_quiet();
        set_instr(0, 2'd2, 32'h0000_0300, 32'h0, 4'b1111);
        bus.data_sram_addr_ok = 1;
        settle();
        got = bus_sample(); e = exp_q.pop_front();
        checks++; if (got !== e) begin failures++; $display("FAIL flush_fields got=%h exp=%h", got, e); end
        cyc();
        bus.data_sram_addr_ok = 0; m_flush = 1;
        settle();
        checks++; if (dmem_busy !== 1'b1) begin failures++; $display("FAIL flush_wait_busy got=%b exp=1", dmem_busy); end
        cyc();
        m_flush = 0;
        set_instr(1, 2'd2, 32'h0000_0400, 32'h0BAD_F00D, 4'b1111);
        for (int i = 0; i < 2; i++) begin
            settle();
            checks++; if (bus.data_sram_req !== 1'b0 || dmem_busy !== 1'b1) begin failures++; $display("FAIL drain%0d req=%b busy=%b exp=0,1", i, bus.data_sram_req, dmem_busy); end
            cyc();
        end
        bus.data_sram_data_ok = 1; bus.data_sram_rdata = 32'hBADB_AD00;
        settle();
        checks++; if (bus.data_sram_req !== 1'b0 || dmem_busy !== 1'b1 || m_rdata !== 32'h1234_5678) begin failures++; $display("FAIL drain_dataok req=%b busy=%b rdata=%h exp=0,1,12345678", bus.data_sram_req, dmem_busy, m_rdata); end
        cyc();
        bus.data_sram_data_ok = 0; bus.data_sram_addr_ok = 1;
        settle();
        got = bus_sample(); e = exp_q.pop_front();
        checks++; if (bus.data_sram_req !== 1'b1 || got !== e) begin failures++; $display("FAIL after_drain req=%b got=%h exp=%h", bus.data_sram_req, got, e); end
        cyc();
        bus.data_sram_addr_ok = 0; bus.data_sram_data_ok = 1;
        settle();
        checks++; if (dmem_busy !== 1'b0) begin failures++; $display("FAIL after_drain_done busy=%b exp=0", dmem_busy); end
        cyc();
        drive_quiet();
    endtask

    task automatic test_req_cancel();
        set_instr(0, 2'd2, 32'h0000_0700, 32'h0, 4'b1111);
        settle();
        cyc();
        m_flush = 1;
        settle();
        checks++; if (bus.data_sram_req !== 1'b1 || dmem_busy !== 1'b1) begin failures++; $display("FAIL cancel_req req=%b busy=%b exp=1,1", bus.data_sram_req, dmem_busy); end
        cyc();
        m_flush = 0; m_req = 0; m_addr = 32'h0; bus.data_sram_addr_ok = 1;
        settle();
        got = bus_sample(); e = exp_q.pop_front();
        checks++; if (bus.data_sram_req !== 1'b1 || got !== e) begin failures++; $display("FAIL cancel_held req=%b got=%h exp=%h", bus.data_sram_req, got, e); end
        cyc();
        bus.data_sram_addr_ok = 0;
        settle();
        checks++; if (bus.data_sram_req !== 1'b0 || dmem_busy !== 1'b1) begin failures++; $display("FAIL cancel_drain req=%b busy=%b exp=0,1", bus.data_sram_req, dmem_busy); end
        cyc();
        bus.data_sram_data_ok = 1;
        settle();
        checks++; if (dmem_busy !== 1'b1) begin failures++; $display("FAIL cancel_drain_ok busy=%b exp=1", dmem_busy); end
        cyc();
        bus.data_sram_data_ok = 0;
        settle();
        checks++; if (dmem_busy !== 1'b0) begin failures++; $display("FAIL cancel_idle busy=%b exp=0", dmem_busy); end
        cyc();
    endtask

    task automatic test_back_to_back();
        set_instr(1, 2'd1, 32'h0000_0502, 32'h5566_0000, 4'b1100);
        bus.data_sram_addr_ok = 1;
        settle();
        got = bus_sample(); e = exp_q.pop_front();
        checks++; if (got !== e) begin failures++; $display("FAIL b2b_store got=%h exp=%h", got, e); end
        cyc();
        bus.data_sram_addr_ok = 0; bus.data_sram_data_ok = 1;
        settle();
        checks++; if (dmem_busy !== 1'b0) begin failures++; $display("FAIL b2b_store_done busy=%b exp=0", dmem_busy); end
        cyc();
        bus.data_sram_data_ok = 0;
        set_instr(0, 2'd1, 32'h0000_0500, 32'h0, 4'b0011);
        bus.data_sram_addr_ok = 1;
        settle();
        got = bus_sample(); e = exp_q.pop_front();
        checks++; if (bus.data_sram_req !== 1'b1 || got !== e) begin failures++; $display("FAIL b2b_load req=%b got=%h exp=%h", bus.data_sram_req, got, e); end
        cyc();
        bus.data_sram_addr_ok = 0; bus.data_sram_data_ok = 1; bus.data_sram_rdata = 32'h0000_CAFE;
        rd_q.push_back(32'h0000_CAFE);
        settle();
        exp_rd = rd_q.pop_front();
        checks++; if (m_rdata !== exp_rd) begin failures++; $display("FAIL b2b_rdata got=%h exp=%h", m_rdata, exp_rd); end
        cyc();
        drive_quiet();
    endtask

    task automatic test_wstrb_sweep();
        for (int i = 0; i < 7; i++) begin
            bus.data_sram_data_ok = 0;
            set_instr(0, sw_size[i], 32'h0000_0800 | {30'd0, sw_lo[i]}, 32'h0, sw_strb[i]);
            bus.data_sram_addr_ok = 1;
            settle();
            got = bus_sample(); e = exp_q.pop_front();
            checks++; if (got !== e) begin failures++; $display("FAIL wstrb%0d got=%h exp=%h", i, got, e); end
            cyc();
            bus.data_sram_addr_ok = 0; bus.data_sram_data_ok = 1;
            bus.data_sram_rdata = 32'hA5A5_0000 | i;
            m_req = 0;
            cyc();
        end
        drive_quiet();
        cyc();
    endtask

    task automatic test_reset_in_req();
        m_req = 1; m_wr = 1; m_size = 2; m_addr = 32'h0000_0900; m_wdata = 32'h11;
        settle();
        cyc();
        settle();
        checks++; if (bus.data_sram_req !== 1'b1) begin failures++; $display("FAIL rst_req_pre got=%b exp=1", bus.data_sram_req); end
        resetn = 0;
        #1;
        checks++; if (bus.data_sram_req !== 1'b0 || dmem_busy !== 1'b0 || m_rdata !== 32'h0) begin failures++; $display("FAIL rst_async req=%b busy=%b rdata=%h exp=0,0,0", bus.data_sram_req, dmem_busy, m_rdata); end
        base = n_accept;
        cyc(); cyc();
        drive_quiet();
        resetn = 1;
        for (int i = 0; i < 3; i++) begin
            settle();
            checks++; if (bus.data_sram_req !== 1'b0 || dmem_busy !== 1'b0) begin failures++; $display("FAIL rst_quiet%0d req=%b busy=%b exp=0,0", i, bus.data_sram_req, dmem_busy); end
            cyc();
        end
        checks++; if (n_accept - base !== 0) begin failures++; $display("FAIL rst_accepts got=%0d exp=0", n_accept - base); end
    endtask

    initial begin
        test_reset();
        test_load_word();
        test_byte_store();
        test_stall_hold();
        test_flush_drain();
        test_req_cancel();
        test_back_to_back();
        test_wstrb_sweep();
        test_reset_in_req();
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL scoreboard_left got=%0d exp=0", exp_q.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_bridge.md
Name: dmem_bridge

Overview:
- Memory-stage data-access bridge between the pipeline M stage and an SRAM-like data bus (req / addr_ok / data_ok).
- Drives `dmem_busy` in the `busy_ok` bundle consumed by the hazard unit.
- Consumes the resulting M-stage stall/flush so each load/store issues exactly once.
- Holds load data while the pipeline is frozen for other reasons, e.g. an instruction-memory miss.

Parameters:
- ADDR_W, 32, data bus address width
- DATA_W, 32, data bus width (fixed 32; wstrb is DATA_W/8)

Ports:
- clk  in  1  system clock, all state on rising edge
- resetn  in  1  asynchronous active-low reset
- m_req  in  1  M-stage instruction is a load/store; already exception-qualified (low if the instruction faulted)
- m_wr  in  1  1 = store, 0 = load
- m_size  in  2  0 = byte, 1 = half, 2 = word
- m_addr  in  ADDR_W  byte address (alignment already checked upstream)
- m_wdata  in  DATA_W  store data, already lane-aligned
- m_stall  in  1  final stall.m from the hazard unit
- m_flush  in  1  final flush.m from the hazard unit
- dmem_busy  out  1  to hazard unit; M-stage access not yet complete
- m_rdata  out  DATA_W  load result for the M/W path
- data_sram_req  out  1  bus request
- data_sram_wr  out  1  bus write
- data_sram_size  out  2  bus size
- data_sram_addr  out  ADDR_W  bus address
- data_sram_wstrb  out  4  byte enables
- data_sram_wdata  out  DATA_W  bus write data
- data_sram_addr_ok  in  1  request accepted this cycle
- data_sram_data_ok  in  1  response (read data / write ack) this cycle
- data_sram_rdata  in  DATA_W  read data, valid with data_ok

Behaviour:
- State machine: IDLE, REQ, WAIT, DONE, DRAIN.
- Reset (resetn low, asynchronous):
  - State goes to IDLE; latched request fields and latched rdata are cleared to 0.
  - data_sram_req = 0, dmem_busy = 0 and m_rdata = 0 while resetn is low.
- dmem_busy must never depend combinationally on m_stall or m_flush (the hazard unit derives them from busy). Its value per state:
  - IDLE: busy = m_req.
  - REQ: busy = 1.
  - WAIT: busy = !data_ok.
  - DONE: busy = 0.
  - DRAIN: busy = 1.
- IDLE:
  - data_sram_req = m_req && !m_flush; bus fields are driven directly from the m_* inputs.
  - On issue, latch wr/size/addr/wdata/wstrb.
  - Issue with addr_ok → WAIT; issue without addr_ok → REQ.
- REQ:
  - req is held at 1 with the latched fields until addr_ok; a request is never withdrawn.
  - On addr_ok: → DRAIN if a cancel flag is set, else → WAIT.
  - m_flush while in REQ sets the cancel flag.
- WAIT:
  - Waits for data_ok; at most one outstanding transaction.
  - On data_ok:
    - m_rdata = data_sram_rdata combinationally that cycle, and rdata is latched.
    - m_flush → IDLE (result discarded).
    - m_stall → DONE.
    - Otherwise → IDLE (the instruction leaves M at this edge).
  - m_flush without data_ok → DRAIN.
- DONE:
  - m_rdata = latched rdata; no bus activity.
  - !m_stall or m_flush → IDLE.
- DRAIN:
  - Waits data_ok, discards the data, → IDLE.
  - The cancel flag is cleared on entering IDLE.
- m_rdata equals the latched value in IDLE, REQ and DRAIN.
- wstrb rules:
  - size 0 → 4'b0001 << addr[1:0].
  - size 1 → addr[1] ? 4'b1100 : 4'b0011.
  - size 2 → 4'b1111.
  - size 3 is reserved and treated as word.
  - For loads, wstrb is still computed; the bus ignores it.
- Boundary cases:
  - addr_ok and data_ok in the same cycle while in IDLE: the access completes in that cycle (busy follows the IDLE rule, so it stays 1 that cycle). The block goes to WAIT, whose data_ok has already been consumed; this case is therefore forbidden by the bus contract (data_ok comes ≥1 cycle after addr_ok).
  - Mid-operation reset abandons any transaction; the bus slave is reset by the same resetn.

Test Plan:
- Load, addr 0x0000_0104, size 2; addr_ok same cycle, data_ok 2 cycles later with 0xDEADBEEF:
  - req is high for 1 cycle with wstrb 1111.
  - busy is high for 3 cycles (issue cycle plus 2 WAIT cycles without data_ok), low in the data_ok cycle.
  - m_rdata = 0xDEADBEEF in the data_ok cycle.
- Byte store, addr 0x...03, wdata 0xAB000000; addr_ok delayed 3 cycles:
  - req and the bus fields stay stable for 4 cycles.
  - wstrb = 1000, wr = 1, exactly one accepted request.
- Load completes (data_ok, rdata 0x12345678) while m_stall stays high 4 more cycles (imem miss):
  - State goes to DONE; busy = 0.
  - m_rdata holds 0x12345678 across all 4 cycles; no second req.
  - Returns to IDLE when m_stall drops.
- m_flush asserted in WAIT before data_ok:
  - State goes to DRAIN; busy = 1 until data_ok, then IDLE.
  - The next m_req issues only after DRAIN exits.
- Half store at addr 0x...02 then immediately a half load at 0x...00 on back-to-back instructions:
  - Two requests with wstrb 1100 then 0011.
  - No idle bubble beyond the data_ok cycle.
- resetn pulsed low while in REQ:
  - req, busy and m_rdata go to 0 asynchronously; state IDLE.
  - After release with m_req = 0, no bus activity.
